// File: rtl/nco_multi_if.sv
// Increment write channel of nco_multi: valid/ready handshake carrying a target
// channel and a new phase increment.
interface nco_multi_if #(
    parameter int CH_W    = 1,
    parameter int PHASE_W = 26
);
    logic               inc_valid;
    logic               inc_ready;
    logic [CH_W-1:0]    inc_chan;
    logic [PHASE_W-1:0] inc_data;

    modport master (output inc_valid, inc_chan, inc_data, input inc_ready);
    modport slave  (input inc_valid, inc_chan, inc_data, output inc_ready);
endinterface

// File: rtl/nco_multi.sv
// Multi-channel NCO: per-channel phase accumulator with wrap-committed increments,
// quarter-wave ROM and linear interpolation. Define NCO_MULTI_AM_EN for a per-channel gain stage.
module nco_multi #(
    parameter int  CHANNELS = 2,
    parameter int  LUT_SIZE = 8,
    parameter int  DECIMALS = 16,
    parameter int  OUT_RES  = 16,
    localparam int PHASE_W  = 2 + LUT_SIZE + DECIMALS,
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [CHANNELS-1:0]         en,
    nco_multi_if.slave                  inc_if,
`ifdef NCO_MULTI_AM_EN
    input  logic [CHANNELS*OUT_RES-1:0] am_gain,
`endif
    output logic [CHANNELS*PHASE_W-1:0] phase_out,
    output logic [CHANNELS*OUT_RES-1:0] sample_out,
    output logic                        sample_valid
);

`ifdef NCO_MULTI_AM_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif
    localparam int ROM_N  = (2 ** LUT_SIZE) + 1;
    localparam int PROD_W = OUT_RES + DECIMALS + 1;
    localparam logic [LUT_SIZE:0] A_TOP = {1'b1, {LUT_SIZE{1'b0}}};
    localparam logic [LUT_SIZE:0] A_ONE = (LUT_SIZE + 1)'(1);

    // Elaboration-time sine table; Horner-form Taylor series to x^19 is exact well below 1 LSB.
    function automatic logic [ROM_N*OUT_RES-1:0] rom_init();
        logic [ROM_N*OUT_RES-1:0] bits;
        real    x, x2, s, amp;
        integer r;
        bits = '0;
        amp  = real'((2 ** (OUT_RES - 1)) - 1);
        for (int k = 0; k < ROM_N; k++) begin
            x  = 3.14159265358979323846 * real'(k) / real'(2 ** (LUT_SIZE + 1));
            x2 = x * x;
            s  = x * (1.0 - x2 / 6.0 * (1.0 - x2 / 20.0 * (1.0 - x2 / 42.0 * (1.0 - x2 / 72.0 *
                 (1.0 - x2 / 110.0 * (1.0 - x2 / 156.0 * (1.0 - x2 / 210.0 * (1.0 - x2 / 272.0 *
                 (1.0 - x2 / 342.0)))))))));
            r  = $rtoi(amp * s + 0.5);
            bits[k*OUT_RES +: OUT_RES] = OUT_RES'(r);
        end
        return bits;
    endfunction

    localparam logic [ROM_N*OUT_RES-1:0] ROM_BITS = rom_init();

    function automatic logic signed [OUT_RES-1:0] rom_rd(input logic [LUT_SIZE:0] a);
        return ROM_BITS[int'(a)*OUT_RES +: OUT_RES];
    endfunction

    logic [CHANNELS-1:0]    w_pend;
    logic [2**CH_W-1:0]     w_pend_pad;
    logic                   w_xfer;
    logic [LAT-1:0]         r_vld;

    // Out-of-range channel numbers read as free and are silently dropped.
    always_comb begin
        w_pend_pad                 = '0;
        w_pend_pad[CHANNELS-1:0]   = w_pend;
    end

    assign inc_if.inc_ready = !w_pend_pad[inc_if.inc_chan];
    assign w_xfer           = inc_if.inc_valid && inc_if.inc_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_vld <= '0;
        else       r_vld <= {r_vld[LAT-2:0], 1'b1};
    end

    assign sample_valid = r_vld[LAT-1];

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [PHASE_W-1:0]         r_acc;
        logic [PHASE_W-1:0]         r_act;
        logic [PHASE_W-1:0]         r_shd;
        logic                       r_pend;
        logic [PHASE_W:0]           w_sum;
        logic                       w_wr;
        logic [LUT_SIZE:0]          r_addr_lo;
        logic [LUT_SIZE:0]          r_addr_hi;
        logic                       r_neg;
        logic [DECIMALS-1:0]        r_frac1;
        logic [DECIMALS-1:0]        r_frac2;
        logic signed [OUT_RES-1:0]  r_lo;
        logic signed [OUT_RES-1:0]  r_hi;
        logic signed [OUT_RES-1:0]  r_smp;
        logic signed [OUT_RES:0]    w_diff;
        logic signed [PROD_W-1:0]   w_prod;
        logic signed [OUT_RES-1:0]  w_lerp;

        assign w_sum    = {1'b0, r_acc} + {1'b0, r_act};
        assign w_wr     = w_xfer && (inc_if.inc_chan == CH_W'(c));
        assign w_pend[c] = r_pend;

        // A pending increment swaps in on the wrap edge, or at once while the channel is halted.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_acc  <= '0;
                r_act  <= '0;
                r_shd  <= '0;
                r_pend <= 1'b0;
            end else begin
                if (en[c]) r_acc <= w_sum[PHASE_W-1:0];
                if (r_pend && (!en[c] || w_sum[PHASE_W])) begin
                    r_act  <= r_shd;
                    r_pend <= 1'b0;
                end else if (w_wr) begin
                    r_shd  <= inc_if.inc_data;
                    r_pend <= 1'b1;
                end
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_addr_lo <= '0;
                r_addr_hi <= '0;
                r_neg     <= 1'b0;
                r_frac1   <= '0;
            end else begin
                if (r_acc[PHASE_W-2]) begin
                    r_addr_lo <= A_TOP - {1'b0, r_acc[DECIMALS +: LUT_SIZE]};
                    r_addr_hi <= A_TOP - {1'b0, r_acc[DECIMALS +: LUT_SIZE]} - A_ONE;
                end else begin
                    r_addr_lo <= {1'b0, r_acc[DECIMALS +: LUT_SIZE]};
                    r_addr_hi <= {1'b0, r_acc[DECIMALS +: LUT_SIZE]} + A_ONE;
                end
                r_neg   <= r_acc[PHASE_W-1];
                r_frac1 <= r_acc[DECIMALS-1:0];
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_lo    <= '0;
                r_hi    <= '0;
                r_frac2 <= '0;
            end else begin
                r_lo    <= r_neg ? -rom_rd(r_addr_lo) : rom_rd(r_addr_lo);
                r_hi    <= r_neg ? -rom_rd(r_addr_hi) : rom_rd(r_addr_hi);
                r_frac2 <= r_frac1;
            end
        end

        always_comb begin
            w_diff = {r_hi[OUT_RES-1], r_hi} - {r_lo[OUT_RES-1], r_lo};
            w_prod = $signed({{(PROD_W-OUT_RES-1){w_diff[OUT_RES]}}, w_diff})
                   * $signed({{(PROD_W-DECIMALS){1'b0}}, r_frac2});
            w_lerp = r_lo + OUT_RES'(w_prod >>> DECIMALS);
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) r_smp <= '0;
            else       r_smp <= w_lerp;
        end

`ifdef NCO_MULTI_AM_EN
        logic signed [2*OUT_RES:0]  w_am;
        logic signed [OUT_RES-1:0]  r_out;

        assign w_am = $signed({{(OUT_RES+1){r_smp[OUT_RES-1]}}, r_smp})
                    * $signed({{(OUT_RES+1){1'b0}}, am_gain[c*OUT_RES +: OUT_RES]});

        always_ff @(posedge clk or posedge reset) begin
            if (reset) r_out <= '0;
            else       r_out <= OUT_RES'(w_am >>> OUT_RES);
        end

        assign sample_out[c*OUT_RES +: OUT_RES] = r_out;
`else
        assign sample_out[c*OUT_RES +: OUT_RES] = r_smp;
`endif
        assign phase_out[c*PHASE_W +: PHASE_W] = r_acc;
    end

endmodule

// File: tb/tb_nco_multi.sv
// Self-checking bench for nco_multi: directed handshake/commit scenarios followed by
// randomized traffic, all checked against a cycle-level behavioural model.
module tb_nco_multi;
    localparam int CH = 2;
    localparam int L  = 8;
    localparam int D  = 16;
    localparam int R  = 16;
    localparam int PW = 2 + L + D;
    localparam int CW = 1;
    localparam longint MOD = longint'(1) << PW;

    logic              clk   = 1'b0;
    logic              reset = 1'b1;
    logic [CH-1:0]     en;
    logic [CH*PW-1:0]  phase_out;
    logic [CH*R-1:0]   sample_out;
    logic              sample_valid;

    nco_multi_if #(.CH_W(CW), .PHASE_W(PW)) inc_if ();

    nco_multi #(.CHANNELS(CH), .LUT_SIZE(L), .DECIMALS(D), .OUT_RES(R)) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .inc_if       (inc_if),
        .phase_out    (phase_out),
        .sample_out   (sample_out),
        .sample_valid (sample_valid)
    );

    always #5 clk = ~clk;

    int     n_tests = 0;
    int     n_fail  = 0;
    longint rom [0:(1<<L)];
    longint m_acc [CH];
    longint m_act [CH];
    longint m_shd [CH];
    bit     m_pend [CH];
    longint m_p1 [CH];
    longint m_p2 [CH];
    longint m_exp [CH];
    int     m_edges;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint ref_sample(input longint p);
        longint q, idx, frac, lo, hi;
        q    = p >> (L + D);
        idx  = (p >> D) % (longint'(1) << L);
        frac = p % (longint'(1) << D);
        if (q % 2 == 1) begin
            lo = rom[int'((1 << L) - idx)];
            hi = rom[int'((1 << L) - idx - 1)];
        end else begin
            lo = rom[int'(idx)];
            hi = rom[int'(idx + 1)];
        end
        if (q >= 2) begin
            lo = -lo;
            hi = -hi;
        end
        return lo + (((hi - lo) * frac) >>> D);
    endfunction

    function automatic longint phase_of(input int c);
        return longint'(phase_out[c*PW +: PW]);
    endfunction

    function automatic longint samp_of(input int c);
        return longint'($signed(sample_out[c*R +: R]));
    endfunction

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_acc[c] = 0; m_act[c] = 0; m_shd[c] = 0; m_pend[c] = 0;
            m_p1[c] = 0;  m_p2[c] = 0;  m_exp[c] = 0;
        end
        m_edges = 0;
    endtask

    // One clock edge of the block: samples leave 3 edges after their phase, increments swap on wrap.
    task automatic model_edge();
        int     sel;
        bit     xfer;
        longint sum;
        sel  = int'(inc_if.inc_chan);
        xfer = inc_if.inc_valid && (sel < CH) && !m_pend[sel];
        for (int c = 0; c < CH; c++) begin
            m_exp[c] = ref_sample(m_p2[c]);
            m_p2[c]  = m_p1[c];
            m_p1[c]  = m_acc[c];
            sum      = m_acc[c] + m_act[c];
            if (en[c]) m_acc[c] = sum % MOD;
            if (m_pend[c] && (!en[c] || sum >= MOD)) begin
                m_act[c]  = m_shd[c];
                m_pend[c] = 0;
            end
        end
        if (xfer) begin
            m_shd[sel]  = longint'(inc_if.inc_data);
            m_pend[sel] = 1;
        end
        m_edges++;
    endtask

    task automatic check_all();
        for (int c = 0; c < CH; c++) begin
            chk($sformatf("phase%0d", c), phase_of(c), m_acc[c]);
            chk($sformatf("sample%0d", c), samp_of(c), m_exp[c]);
        end
        chk("valid", longint'(sample_valid), longint'(m_edges >= 3));
        chk("ready", longint'(inc_if.inc_ready), longint'(!m_pend[int'(inc_if.inc_chan)]));
    endtask

    task automatic check_reset_state(input string tag);
        for (int c = 0; c < CH; c++) begin
            chk($sformatf("%s_phase%0d", tag, c), phase_of(c), 0);
            chk($sformatf("%s_sample%0d", tag, c), samp_of(c), 0);
        end
        chk($sformatf("%s_valid", tag), longint'(sample_valid), 0);
        chk($sformatf("%s_ready", tag), longint'(inc_if.inc_ready), 1);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic write(input int ch, input longint d);
        inc_if.inc_valid = 1'b1;
        inc_if.inc_chan  = CW'(ch);
        inc_if.inc_data  = PW'(d);
    endtask

    task automatic idle();
        inc_if.inc_valid = 1'b0;
    endtask

    // Called at a falling edge; reset lands mid-cycle, is held across one rising edge.
    task automatic async_reset();
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_reset_state("arst");
        @(posedge clk);
        @(negedge clk);
        check_all();
        reset = 1'b0;
    endtask

    initial begin
        en               = '0;
        inc_if.inc_valid = 1'b0;
        inc_if.inc_chan  = '0;
        inc_if.inc_data  = '0;
        for (int k = 0; k <= (1 << L); k++)
            rom[k] = longint'($rtoi($floor(32767.0 * $sin(3.14159265358979323846 * k / (2.0 ** (L + 1))) + 0.5)));
        model_reset();
        @(negedge clk);
        check_reset_state("por");
        reset = 1'b0;

        en = '1;
        repeat (6) step();

        en = '0;
        write(0, longint'(1) << 24);
        step();
        idle();
        step();
        en = 2'b01;
        repeat (10) step();

        async_reset();
        en = '0;
        write(0, longint'(1) << 15);
        step();
        idle();
        step();
        en = 2'b01;
        step();
        chk("t3_phase", phase_of(0), longint'(1) << 15);
        repeat (3) step();
        chk("t3_interp", samp_of(0), 100);

        async_reset();
        en = '0;
        write(1, longint'(1) << 24);
        step();
        idle();
        step();
        en = '1;
        step();
        chk("t4_acc_a", phase_of(1), longint'(1) << 24);
        write(1, longint'(1) << 23);
        step();
        chk("t4_ready_low", longint'(inc_if.inc_ready), 0);
        write(0, longint'(1) << 20);
        step();
        chk("t4_acc_b", phase_of(1), longint'(3) << 24);
        write(1, longint'(1) << 22);
        step();
        chk("t4_acc_wrap", phase_of(1), 0);
        chk("t4_ready_back", longint'(inc_if.inc_ready), 1);
        idle();
        step();
        step();
        chk("t4_acc_new", phase_of(1), longint'(1) << 24);

        write(1, longint'(1) << 24);
        step();
        for (int i = 0; i < 12; i++) begin
            write(0, longint'($urandom_range(1, 255)) << 17);
            step();
        end
        idle();
        step();

        async_reset();
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < CH; c++) en[c] = ($urandom_range(0, 7) != 0);
            inc_if.inc_valid = ($urandom_range(0, 1) == 1);
            inc_if.inc_chan  = CW'($urandom_range(0, CH - 1));
            case ($urandom_range(0, 3))
                0:       inc_if.inc_data = PW'($urandom);
                1:       inc_if.inc_data = PW'(longint'(1) << $urandom_range(10, PW - 1));
                2:       inc_if.inc_data = '0;
                default: inc_if.inc_data = PW'($urandom) >> 6;
            endcase
            if ($urandom_range(0, 399) == 0) async_reset();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/nco_multi.md
Name: nco_multi

Overview:
- Parametrised multi-channel numerically controlled oscillator. It is the successor of the single-channel accumulator → index-select → quarter-wave LUT → lerp chain.
- Each channel has its own phase accumulator and a double-buffered increment. Increment writes use a valid/ready handshake and take effect only at that channel's phase wrap, so frequency changes are glitch-free.
- Sine synthesis is a fixed-latency pipeline with a per-channel registered quarter-wave ROM and linear interpolation.
- The block sits between the distance-to-increment logic and the DAC/PWM output.

Parameters:
- CHANNELS, 2: number of independent oscillators (≥1).
- LUT_SIZE, 8: log2 of quarter-wave table steps; the table has 2^LUT_SIZE+1 entries.
- DECIMALS, 16: fractional phase bits used for interpolation.
- OUT_RES, 16: signed sample width.
- PHASE_W (localparam), 2+LUT_SIZE+DECIMALS: accumulator and increment width.
- CH_W (localparam), max(1,$clog2(CHANNELS)).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- en  in  CHANNELS  per-channel run enable.
- inc_valid  in  1  increment write request.
- inc_ready  out  1  = !pending[inc_chan] (combinational).
- inc_chan  in  CH_W  target channel.
- inc_data  in  PHASE_W  new phase increment, unsigned.
- phase_out  out  CHANNELS*PHASE_W  accumulator values, channel 0 in the LSBs.
- sample_out  out  CHANNELS*OUT_RES  signed samples, channel 0 in the LSBs.
- sample_valid  out  1  pipeline-full indicator.

Behaviour:
- Reset (asynchronous, takes effect immediately): acc, active_inc, shadow_inc, pending, all pipeline registers, sample_out and sample_valid all clear to 0. Consequently inc_ready=1.
- Handshake: a transfer occurs at a posedge with inc_valid&&inc_ready. It sets shadow_inc[inc_chan]<=inc_data and pending[inc_chan]<=1. While pending, writes to that channel stall. Other channels remain writable.
- Accumulator (stage 0), per channel, when en=1: {carry,acc}<=acc+active_inc, modulo 2^PHASE_W.
- Commit: at an edge where pending and carry=1 (and en=1), acc takes the sum formed with the old increment; active_inc<=shadow_inc; pending<=0. The new increment is used from the next edge.
- Disabled channel (en=0): acc holds. If pending, commit happens at the next edge regardless of carry.
- Stage 1 (registered index select), splitting acc into q=acc[PHASE_W-1:PHASE_W-2], idx=next LUT_SIZE bits, frac=low DECIMALS bits:
  - q even: addr_lo=idx, addr_hi=idx+1.
  - q odd: addr_lo=2^LUT_SIZE-idx, addr_hi=2^LUT_SIZE-idx-1.
  - neg=q[1].
- Stage 2: synchronous ROM read with ROM[k]=round((2^(OUT_RES-1)-1)*sin(πk/2^(LUT_SIZE+1))). Negate both values if neg. frac is delayed to align.
- Stage 3: sample=lo+(((hi-lo)*frac)>>>DECIMALS).
  - Signed; the intermediate product is OUT_RES+DECIMALS+1 bits.
  - The result is registered into sample_out.
  - No overflow is possible, because the result is bounded by the table.
- Latency: 3 clk from the phase_out value to the corresponding sample_out.
- sample_valid rises on the 3rd edge after reset deasserts, then stays 1. en does not affect it; a disabled channel repeats its held sample.
- Wrap: accumulator overflow discards the carry beyond commit detection. An increment of 0 freezes phase while keeping en=1 semantics, so commit occurs only via en=0.
- Reset mid-operation: pending writes are lost and the pipeline flushes; sample_valid waits another 3 edges.

Optional Feature:
- Macro NCO_MULTI_AM_EN.
- When defined:
  - Adds input port am_gain, CHANNELS*OUT_RES bits, unsigned Q0.OUT_RES per channel.
  - Adds stage 4: sample_out=(sample*am_gain)>>>OUT_RES, signed.
  - Latency becomes 4 and sample_valid rises on the 4th edge.
- When undefined: no am_gain port, latency 3.

Test Plan:
1. Reset release, en=all 1, no writes → phase_out=0 and sample_out=0 forever; sample_valid=1 from the 3rd edge.
2. Ch0 write inc=2^24, no carry pending until the first wrap. With en=0 the write commits next edge; then en=1 → samples cycle 0, 32767, 0, -32767 with latency 3.
3. Ch0 write inc=2^15 (commit via en=0), run → at acc=2^15, sample=(0*32768 + 201*32768)>>16 = 100, where ROM[1]=201.
4. Ch1 active inc=2^24, write 2^23 at acc=2^24 → inc_ready for ch1 low next cycle. Acc goes 2^25, 3·2^24, 0 (carry, commit), then 2^23, 2^24; ready returns 1 after the commit edge. Ch0 writes are accepted meanwhile.
5. Simultaneous: inc_valid to a pending channel → no transfer, and shadow_inc unchanged. A write to a free channel on the same edge the other commits → both succeed.
6. Assert reset asynchronously mid-cycle with pending=1 → outputs 0 immediately, pending cleared, inc_ready=1; sample_valid returns 3 edges after release.
